mandelbrot_pixel_collector: RTL
===============================

// Module: mandelbrot_pixel_collector
// PURPOSE
// - Host-side driver/consumer of the mandelbrot core's one-pixel-per-run handshake.
// - Issues core_run pulses, waits for each pixel to finish, captures the 4-bit core_ctr_out.
// - Packs two pixels per byte and streams bytes through an internal FIFO on a valid/ready port.
// - Sits between the mandelbrot core and the downstream frame store / memory writer.
// PARAMETERS
// - FIFO_DEPTH  4   byte FIFO entries; power of two, >= 2
// - CNTWIDTH    17  width of pixel_cnt; must cover core WIDTH*HEIGHT (320*240 = 76800)
// PORTS
// - clk           in   1         system clock; every register is clocked on the rising edge
// - rst           in   1         asynchronous, active-high reset
// - start         in   1         request a frame; sampled only in IDLE
// - busy          out  1         high from start acceptance until frame_done
// - frame_done    out  1         one-cycle pulse when the m_last byte is accepted
// - pixel_cnt     out  CNTWIDTH  number of pixels captured in the current frame
// - core_run      out  1         one-cycle run pulse to the core
// - core_running  in   1         core busy (high while the core computes a pixel)
// - core_ctr_out  in   4         pixel value; valid in the cycle core_running falls
// - core_finished in   1         core frame-complete flag
// - m_data        out  8         byte: first pixel of the pair in [7:4], second in [3:0]
// - m_valid       out  1         FIFO not empty
// - m_ready       in   1         downstream accept; a transfer happens when m_valid & m_ready
// - m_last        out  1         marks the final byte of the frame
// BEHAVIOUR
// - Reset values: all outputs 0, FIFO empty, nibble buffer empty, state IDLE.
// - Reset mid-frame: the frame is abandoned and buffered bytes are lost; the core has its own reset.
// - FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, DRAIN.
//   - IDLE: if start is high, clear pixel_cnt and the nibble buffer, set busy, go to ISSUE.
//   - ISSUE: stall while fifo_count == FIFO_DEPTH. Otherwise drive core_run=1 for exactly one cycle, then go to WAIT_HI.
//   - WAIT_HI: wait for core_running==1. There is no timeout; a core that never starts hangs the FSM, and this is a bench error.
//   - WAIT_LO: on core_running==0, capture core_ctr_out and increment pixel_cnt.
//     - If the nibble buffer is empty, store the value as the high nibble.
//     - If the buffer holds a nibble, push {hi, value} and clear the buffer.
//     - If core_finished==1 in the same cycle: this is the final pixel.
//       - With an odd pixel count, push {value, 4'h0}.
//       - The final push carries m_last=1; then go to DRAIN.
//     - Otherwise go back to ISSUE.
//   - DRAIN: when the last byte transfers, pulse frame_done, drop busy, go to IDLE.
// - Flow control: the free-slot check in ISSUE guarantees room for the push at capture time, because pops only ever free slots.
// - Pixel latency: core_run is high in cycle t; the earliest capture is cycle t+2.
// - Byte latency: a pushed byte is visible on m_data/m_valid one cycle after the push.
// - FIFO stores 9 bits per entry ({last, data}); m_last = stored last bit of the head entry.
// - A simultaneous push and pop in one cycle keeps fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
// - start outside IDLE is ignored. start held high across frames re-launches the next frame right after IDLE.
// - pixel_cnt saturates at 2^CNTWIDTH-1; it never wraps.
// STRUCTURE
// - Shared package mandelbrot_pkg:
//   - state enum: IDLE, ISSUE, WAIT_HI, WAIT_LO, DRAIN
//   - PIX_W=4, BYTE_W=8
// - Sub-module: mandelbrot_byte_fifo
//   - sync FIFO, 9-bit entries, depth FIFO_DEPTH
//   - ports: push, pop, full, empty, count
// - The FSM, the nibble packer and pixel_cnt stay in the top module.
// TESTING
// - Bench uses a behavioural core model: WIDTH=4, HEIGHT=2, fixed latency of 3 cycles, values 1..8.
// - Full frame, m_ready=1 -> bytes 0x12,0x34,0x56,0x78; m_last only on 0x78; one frame_done pulse; pixel_cnt=8.
// - Odd frame (WIDTH=3, HEIGHT=1), values 0xA,0xB,0xC -> bytes 0xAB, then 0xC0 with m_last=1.
// - Backpressure, m_ready=0, FIFO_DEPTH=2 -> no core_run after the 4th capture; release m_ready -> all 4 bytes arrive in order.
// - Random m_ready (50%) across 3 frames -> every byte matches the model; no FIFO overflow or underflow; busy drops after each frame.
// - Assert rst during WAIT_LO -> next cycle all outputs 0 and state IDLE; a following start runs a clean frame.
// - start pulsed while busy=1 -> ignored; exactly one frame_done per accepted start.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// rtl/mandelbrot_pkg.sv - shared types and widths for the mandelbrot pixel collector
package mandelbrot_pkg;

    localparam int PIX_W  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        DRAIN
    } state_t;

endpackage

// File: rtl/mandelbrot_byte_fifo.sv
// rtl/mandelbrot_byte_fifo.sv - synchronous FIFO holding {last, byte} entries
module mandelbrot_byte_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mandelbrot_pixel_collector.sv
// rtl/mandelbrot_pixel_collector.sv - drives the core per pixel, packs nibble pairs, streams bytes
module mandelbrot_pixel_collector
    import mandelbrot_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNTWIDTH   = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                frame_done,
    output logic [CNTWIDTH-1:0] pixel_cnt,
    output logic                core_run,
    input  logic                core_running,
    input  logic [PIX_W-1:0]    core_ctr_out,
    input  logic                core_finished,
    output logic [BYTE_W-1:0]   m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    state_t            state_nxt;
    logic [PIX_W-1:0]  hi_nib;
    logic              nib_valid;
    logic              capture;
    logic              push;
    logic [BYTE_W:0]   push_data;
    logic              pop;
    logic [BYTE_W:0]   head;
    logic              full;
    logic              empty;
    logic [CW-1:0]     fifo_count;
    logic              head_valid;

    mandelbrot_byte_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (BYTE_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign head_valid = (fifo_count != '0);
    assign m_valid    = !empty;
    assign m_data     = head_valid ? head[BYTE_W-1:0] : '0;
    assign m_last     = head_valid && head[BYTE_W];
    assign pop        = m_valid && m_ready;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        core_run   = 1'b0;
        capture    = 1'b0;
        push       = 1'b0;
        push_data  = '0;
        frame_done = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            // Room is reserved before the run; only pops can happen until capture
            ISSUE: begin
                if (!full) begin
                    core_run  = 1'b1;
                    state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: if (core_running) state_nxt = WAIT_LO;
            WAIT_LO: begin
                if (!core_running) begin
                    capture = 1'b1;
                    if (nib_valid) begin
                        push      = 1'b1;
                        push_data = {core_finished, hi_nib, core_ctr_out};
                    end else if (core_finished) begin
                        push      = 1'b1;
                        push_data = {1'b1, core_ctr_out, {PIX_W{1'b0}}};
                    end
                    state_nxt = core_finished ? DRAIN : ISSUE;
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hi_nib    <= '0;
            nib_valid <= 1'b0;
            pixel_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                pixel_cnt <= '0;
                nib_valid <= 1'b0;
            end
            if (capture) begin
                if (pixel_cnt != '1) pixel_cnt <= pixel_cnt + 1'b1;
                if (nib_valid || core_finished) begin
                    nib_valid <= 1'b0;
                end else begin
                    hi_nib    <= core_ctr_out;
                    nib_valid <= 1'b1;
                end
            end
        end
    end

endmodule
